// File: rtl/video_ts_pkg.sv
// Shared types and constants for the TS sprite scanline scheduler:
// descriptor field positions, scheduler FSM states and a clog2 helper.
package video_ts_pkg;

  // R0: Y placement and flags
  localparam int unsigned YcrdMsb   = 8;
  localparam int unsigned YszLsb    = 9;
  localparam int unsigned YszMsb    = 11;
  localparam int unsigned ActBit    = 13;
  localparam int unsigned LeapBit   = 14;
  localparam int unsigned YflpBit   = 15;
  // R1: X placement
  localparam int unsigned XcrdMsb   = 8;
  localparam int unsigned XszLsb    = 9;
  localparam int unsigned XszMsb    = 11;
  localparam int unsigned XflpBit   = 15;
  // R2: tile number (upper bits select line block, lower bits the address) and palette
  localparam int unsigned TaddrMsb  = 5;
  localparam int unsigned TlineLsb  = 6;
  localparam int unsigned TnumMsb   = 11;
  localparam int unsigned PalLsb    = 12;
  localparam int unsigned PalMsb    = 15;

  typedef enum logic [2:0] {
    StIdle,
    StFetch0,
    StChk0,
    StLat1,
    StLat2,
    StIssue,
    StDone
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/video_ts_sfile.sv
// Sprite descriptor file: simple dual-port RAM, registered read, read-old on collision.
module video_ts_sfile #(
  parameter int unsigned Depth = 255,
  parameter int unsigned Aw    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [Aw-1:0] waddr_i,
  input  logic [15:0]   wdata_i,
  input  logic [Aw-1:0] raddr_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/video_ts_spr_sched.sv
// Sprite scanline scheduler: walks the descriptor file on each start and issues one
// render task per Y-visible sprite, tracking layers (leap sprites) and a per-line limit.
module video_ts_spr_sched
  import video_ts_pkg::*;
#(
  parameter int unsigned NSPR   = 85,
  parameter int unsigned LAYERS = 3,
  parameter int unsigned MAXL   = 64,
  localparam int unsigned AW    = clog2(3 * NSPR),
  localparam int unsigned LW    = (LAYERS > 1) ? clog2(LAYERS) : 1,
  localparam int unsigned CW    = clog2(MAXL + 1)
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic [8:0]        line,
  input  logic              s_en,
  input  logic [7:0]        sgpage,
  input  logic              sfile_we,
  input  logic [AW-1:0]     sfile_addr,
  input  logic [15:0]       sfile_data,
  output logic              tsk_valid,
  input  logic              tsk_ready,
  output logic [8:0]        tsk_x,
  output logic [2:0]        tsk_xs,
  output logic              tsk_xf,
  output logic [8:0]        tsk_line,
  output logic [5:0]        tsk_addr,
  output logic [3:0]        tsk_pal,
  output logic [7:0]        tsk_page,
  output logic [LW-1:0]     tsk_layer,
  output logic [LAYERS-1:0] layer_done,
  output logic              busy,
  output logic              ovf,
  output logic [CW-1:0]     spr_cnt
);

  localparam int unsigned IW = clog2(NSPR + 1);

  state_e            state_q;
  logic [IW-1:0]     idx_q;
  logic [AW-1:0]     base_q;
  logic [LW-1:0]     layer_q;
  logic [CW-1:0]     spr_cnt_q;
  logic              ovf_q, busy_q, tsk_valid_q, leap_q, tsk_xf_q;
  logic [LAYERS-1:0] layer_done_q;
  logic [8:0]        line_q, tsk_x_q, tsk_line_q;
  logic [5:0]        off_q, tsk_addr_q;
  logic [2:0]        tsk_xs_q;
  logic [3:0]        tsk_pal_q;
  logic [7:0]        tsk_page_q;

  logic [15:0]       rdata;
  logic [AW-1:0]     raddr;
  logic [8:0]        sl;
  logic [5:0]        ymax, off;
  logic              vis, adv, adv_leap, last_layer, cnt_hit, idx_end, term;
  logic [IW-1:0]     idx_n;
  logic [CW-1:0]     cnt_n;
  logic [LAYERS-1:0] rest_mask, cur_mask;
  logic              unused_rdata;

  video_ts_sfile #(
    .Depth (3 * NSPR),
    .Aw    (AW)
  ) u_sfile (
    .clk_i   (clk),
    .we_i    (sfile_we),
    .waddr_i (sfile_addr),
    .wdata_i (sfile_data),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  // Address is presented one state ahead of the state that consumes the data.
  always_comb begin
    unique case (state_q)
      StChk0:  raddr = base_q + AW'(1);
      StLat1:  raddr = base_q + AW'(2);
      default: raddr = base_q;
    endcase
  end

  assign sl   = line_q - rdata[YcrdMsb:0];
  assign ymax = {rdata[YszMsb:YszLsb], 3'b111};
  assign vis  = rdata[ActBit] && (sl <= {3'b000, ymax});
  assign off  = rdata[YflpBit] ? ymax - sl[5:0] : sl[5:0];

  assign adv        = (state_q == StChk0 && !vis) || (state_q == StIssue && tsk_ready);
  assign adv_leap   = (state_q == StChk0) ? rdata[LeapBit] : leap_q;
  assign cnt_n      = spr_cnt_q + CW'(state_q == StIssue);
  assign idx_n      = idx_q + IW'(1);
  assign idx_end    = idx_n == IW'(NSPR);
  assign cnt_hit    = cnt_n == CW'(MAXL);
  assign last_layer = layer_q == LW'(LAYERS - 1);
  assign term       = idx_end || (adv_leap && last_layer) || cnt_hit;
  assign rest_mask  = {LAYERS{1'b1}} << layer_q;
  assign cur_mask   = LAYERS'(1) << layer_q;

  assign unused_rdata = ^rdata[14:12];

  always_ff @(posedge clk) begin
    if (res) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      base_q       <= '0;
      layer_q      <= '0;
      spr_cnt_q    <= '0;
      ovf_q        <= 1'b0;
      busy_q       <= 1'b0;
      tsk_valid_q  <= 1'b0;
      layer_done_q <= '0;
      line_q       <= '0;
      off_q        <= '0;
      leap_q       <= 1'b0;
      tsk_x_q      <= '0;
      tsk_xs_q     <= '0;
      tsk_xf_q     <= 1'b0;
      tsk_line_q   <= '0;
      tsk_addr_q   <= '0;
      tsk_pal_q    <= '0;
      tsk_page_q   <= '0;
    end else begin
      layer_done_q <= '0;
      if (start) begin
        // Full restart from any state; the aborted scan reports no layers.
        idx_q       <= '0;
        base_q      <= '0;
        layer_q     <= '0;
        spr_cnt_q   <= '0;
        ovf_q       <= 1'b0;
        tsk_valid_q <= 1'b0;
        line_q      <= line;
        busy_q      <= s_en;
        if (s_en) begin
          state_q <= StFetch0;
        end else begin
          state_q      <= StDone;
          layer_done_q <= '1;
        end
      end else begin
        unique case (state_q)
          StFetch0: state_q <= StChk0;
          StChk0: begin
            if (vis) begin
              off_q   <= off;
              leap_q  <= rdata[LeapBit];
              state_q <= StLat1;
            end
          end
          StLat1: begin
            tsk_x_q  <= rdata[XcrdMsb:0];
            tsk_xs_q <= rdata[XszMsb:XszLsb];
            tsk_xf_q <= rdata[XflpBit];
            state_q  <= StLat2;
          end
          StLat2: begin
            tsk_line_q  <= {rdata[TnumMsb:TlineLsb], 3'b000} + {3'b000, off_q};
            tsk_addr_q  <= rdata[TaddrMsb:0];
            tsk_pal_q   <= rdata[PalMsb:PalLsb];
            tsk_page_q  <= sgpage;
            tsk_valid_q <= 1'b1;
            state_q     <= StIssue;
          end
          StIssue: begin
            if (tsk_ready) begin
              tsk_valid_q <= 1'b0;
              spr_cnt_q   <= cnt_n;
            end
          end
          default: ;
        endcase
        if (adv) begin
          idx_q  <= idx_n;
          base_q <= base_q + AW'(3);
          if (term) begin
            state_q      <= StDone;
            busy_q       <= 1'b0;
            layer_done_q <= rest_mask;
            ovf_q        <= cnt_hit && !idx_end;
          end else begin
            state_q <= StFetch0;
            if (adv_leap) begin
              layer_done_q <= cur_mask;
              layer_q      <= layer_q + LW'(1);
            end
          end
        end
      end
    end
  end

  assign tsk_valid  = tsk_valid_q;
  assign tsk_x      = tsk_x_q;
  assign tsk_xs     = tsk_xs_q;
  assign tsk_xf     = tsk_xf_q;
  assign tsk_line   = tsk_line_q;
  assign tsk_addr   = tsk_addr_q;
  assign tsk_pal    = tsk_pal_q;
  assign tsk_page   = tsk_page_q;
  assign tsk_layer  = layer_q;
  assign layer_done = layer_done_q;
  assign busy       = busy_q;
  assign ovf        = ovf_q;
  assign spr_cnt    = spr_cnt_q;

endmodule

// File: doc/video_ts_spr_sched.md
# video_ts_spr_sched

Parametrised sprite scanline scheduler for the TS video pipeline. On every `start` it walks an internal sprite descriptor file (SFile), tests each active sprite for Y-visibility on the current line, and issues one render task per visible sprite to the TS renderer over a valid/ready handshake. Compared to the current TS sprite path it adds:
- a configurable sprite count;
- a configurable layer count;
- a per-line sprite limit with overflow reporting.

It also exposes the layer index of every task.

## Interface
Parameters:
- `NSPR`, 85, number of 3-word descriptors; SFile depth is 3*NSPR words, address width `AW = clog2(3*NSPR)`.
- `LAYERS`, 3, number of sprite layers separated by leap sprites.
- `MAXL`, 64, maximum tasks issued per line (1..NSPR).

Ports (sync reset active-high; one clock):
- `clk  in  1` — video clock.
- `res  in  1` — synchronous, active-high reset.
- `start  in  1` — one-cycle pulse; begin a line scan.
- `line  in  9` — current bitmap line.
- `s_en  in  1` — sprites enabled; sampled on `start`.
- `sgpage  in  8` — sprite graphics page, passed through to `tsk_page`.
- `sfile_we  in  1` — SFile write strobe.
- `sfile_addr  in  AW` — SFile write address.
- `sfile_data  in  16` — SFile write data.
- `tsk_valid  out  1` — task available.
- `tsk_ready  in  1` — renderer accepts the task.
- `tsk_x  out  9`, `tsk_xs  out  3`, `tsk_xf  out  1` — task X position, X size and X flip.
- `tsk_line  out  9`, `tsk_addr  out  6` — task bitmap line and graphics address.
- `tsk_pal  out  4`, `tsk_page  out  8` — task palette and graphics page.
- `tsk_layer  out  clog2(LAYERS)` — layer of the task.
- `layer_done  out  LAYERS` — one-hot pulses, one per completed layer.
- `busy  out  1` — scan in progress.
- `ovf  out  1` — sticky until the next `start`; set when the line hit `MAXL`.
- `spr_cnt  out  clog2(MAXL+1)` — number of tasks issued on this line.

## Operation
Descriptor layout:
- R0: `ycrd[8:0]`, `ysz[11:9]`, `act[13]`, `leap[14]`, `yflp[15]`.
- R1: `xcrd[8:0]`, `xsz[11:9]`, `xflp[15]`.
- R2: `tnum[11:0]`, `pal[15:12]`.

Visibility and derived fields (all values 9-bit, wrapping):
- `sl = line - ycrd`; `ymax = {ysz,3'b111}`; a sprite is visible when `act && sl <= ymax`.
- `off = yflp ? ymax - sl[5:0] : sl[5:0]`.
- `tsk_line = {tnum[11:6],3'b0} + off`; `tsk_addr = tnum[5:0]`; `tsk_page = sgpage`.

FSM states: IDLE, FETCH0, CHK0, LAT1, LAT2, ISSUE, DONE.
- IDLE: on `start && s_en`, clear index, layer, count and `ovf`, then go to FETCH0. On `start && !s_en`, pulse all `layer_done` bits, then go to DONE.
- FETCH0: present the read address `3*idx`.
- CHK0, R0 data valid:
  - Not visible: if `leap`, pulse the `layer_done` bit and increment the layer. Then `idx++` and go to FETCH0.
  - Visible: latch `off` and `leap`, present `3*idx+1`, go to LAT1.
- LAT1: latch the R1 fields, present `+2`, go to LAT2.
- LAT2: latch the R2 fields, go to ISSUE.
- ISSUE: hold `tsk_valid` until `tsk_ready`. On handshake, `spr_cnt++`, apply the latched leap to the layer, `idx++`, and go to FETCH0.
- Termination, to DONE, checked after every index or layer advance: any of `idx == NSPR`, layer advanced past `LAYERS-1`, or `spr_cnt == MAXL`.
  - On termination, pulse all not-yet-done layers in the same cycle.
  - `ovf` is set only for the `spr_cnt == MAXL` cause, and only if a further index remains unscanned.
- DONE: idle until the next `start`.

## Timing
- Reset: FSM in IDLE. All outputs are 0: `tsk_valid`, `busy`, `ovf`, `spr_cnt`, `layer_done` and all task fields.
- SFile read: address registered, data one cycle later. Write and read at the same address in the same cycle returns old data. Writes are allowed at any time.
- Throughput: an invisible sprite takes 2 cycles. A visible sprite takes 4 cycles plus the `tsk_ready` wait. The first task appears at `tsk_valid` 5 cycles after `start`.
- Task fields are stable while `tsk_valid` is high. `tsk_valid` never drops without a handshake, except on `res` or `start`.
- `start` in any state, including mid-ISSUE, is a full restart. `tsk_valid` drops the following cycle and no `layer_done` pulses for the aborted scan.
- `busy` is high from the cycle after `start` until DONE is entered.

## Structure
- Shared package `video_ts_pkg`:
  - descriptor field bit positions;
  - FSM state enum;
  - `clog2` helper.
- Sub-module `video_ts_sfile`: simple dual-port RAM, depth `3*NSPR` x 16, registered read address, infers block RAM.

## Test plan
- NSPR=4. Sprite 0 with ycrd=10, ysz=0, act=1, line=12, tnum=0x0C5, yflp=0 → one task with `tsk_line`=0x1A, `tsk_addr`=5, layer 0. `tsk_valid` first asserted 5 cycles after `start`.
- Same sprite with yflp=1 → `tsk_line` = 0x18+5 = 0x1D. With ycrd=500 and line=2 (wrapped sl=14) and ysz=1 → visible, off=14.
- LAYERS=3, leap set on sprite 1 (invisible) and on sprite 3 (visible) → `layer_done[0]` pulses at CHK0 of sprite 1. `layer_done[1]` pulses at the sprite 3 handshake. `layer_done[2]` pulses at the end of the list.
- MAXL=2, four visible sprites → exactly 2 tasks, then `ovf=1` and `spr_cnt=2`. With exactly 2 visible sprites as the last two entries → `ovf=0`.
- Hold `tsk_ready=0` for 20 cycles → task fields are stable throughout. Then pulse `start` → `tsk_valid=0` next cycle and the scan restarts at idx 0.
- `s_en=0` → all `layer_done` bits pulse together and no task is issued. `res` mid-ISSUE → all outputs 0 the next cycle.
